// File: rtl/x86_state_regs.sv
// x86_state_regs: live and shadow architectural register files with
// lane-masked writes, a multi-cycle checkpoint/rollback engine and a
// free-running cycle counter.
// Optional feature macro: X86_STATE_STAMP_EN. When it is defined, the low CNT_W
// bits of registers 0..3 load the cycle counter every IDLE cycle, and an
// accepted write to the same lane in that cycle overrides the stamp.
module x86_state_regs #(
  parameter int NREGS = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  output logic                       wr_ready,
  input  logic [$clog2(NREGS)-1:0]   wr_idx,
  input  logic [1:0]                 wr_size,
  input  logic [XLEN-1:0]            wr_data,
  input  logic [$clog2(NREGS)-1:0]   rd_idx_a,
  input  logic [$clog2(NREGS)-1:0]   rd_idx_b,
  output logic [XLEN-1:0]            rd_data_a,
  output logic [XLEN-1:0]            rd_data_b,
  input  logic                       ckpt_req,
  output logic                       ckpt_ack,
  input  logic                       rb_req,
  output logic                       rb_ack,
  output logic                       rb_err,
  output logic                       ckpt_valid,
  output logic                       busy,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [NREGS*XLEN-1:0]      state_out
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CKPT = 2'd1;
  localparam logic [1:0] ST_RB   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             ckpt_valid_q, ckpt_valid_d;
  logic             ckpt_ack_q, ckpt_ack_d;
  logic             rb_ack_q, rb_ack_d;
  logic             rb_err_q, rb_err_d;
  logic [XLEN-1:0]  live_q   [NREGS];
  logic [XLEN-1:0]  live_d   [NREGS];
  logic [XLEN-1:0]  shadow_q [NREGS];
  logic [XLEN-1:0]  shadow_d [NREGS];
  logic [XLEN-1:0]  wr_mask_s;
  logic             wr_fire_s;

  // Bit mask of the lanes touched by a write of the given size.
  function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] size);
    logic [XLEN-1:0] mask;
    case (size)
      2'd0:    mask = XLEN'(16'h00FF);
      2'd1:    mask = XLEN'(16'hFF00);
      2'd2:    mask = XLEN'(16'hFFFF);
      2'd3:    mask = {XLEN{1'b1}};
      default: mask = {XLEN{1'b0}};
    endcase
    return mask;
  endfunction

  assign wr_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign wr_fire_s  = wr_en && wr_ready;
  assign wr_mask_s  = lane_mask(wr_size);
  assign rd_data_a  = live_q[rd_idx_a];
  assign rd_data_b  = live_q[rd_idx_b];
  assign cycle_cnt  = cycle_cnt_q;
  assign ckpt_valid = ckpt_valid_q;
  assign ckpt_ack   = ckpt_ack_q;
  assign rb_ack     = rb_ack_q;
  assign rb_err     = rb_err_q;

  // Flatten the live file onto state_out, register i at bits[i*XLEN +: XLEN].
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_state_out
    assign state_out[gi*XLEN +: XLEN] = live_q[gi];
  end

  // Next-state logic: FSM sequencing, copy engine, writes and optional stamping.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ckpt_valid_d = ckpt_valid_q;
    ckpt_ack_d   = 1'b0;
    rb_ack_d     = 1'b0;
    rb_err_d     = 1'b0;
    cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
    live_d       = live_q;
    shadow_d     = shadow_q;

    case (state_q)
      ST_IDLE: begin
        if (rb_req) begin
          if (ckpt_valid_q) begin
            state_d = ST_RB;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            // Nothing to roll back to: report and complete immediately.
            rb_err_d = 1'b1;
            rb_ack_d = 1'b1;
          end
        end else if (ckpt_req) begin
          state_d = ST_CKPT;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CKPT: begin
        shadow_d[idx_q] = live_q[idx_q];
        if (idx_q == LAST_IDX) begin
          state_d      = ST_IDLE;
          ckpt_valid_d = 1'b1;
          ckpt_ack_d   = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RB: begin
        live_d[idx_q] = shadow_q[idx_q];
        if (idx_q == LAST_IDX) begin
          state_d  = ST_IDLE;
          rb_ack_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Writes are only accepted in IDLE, so they never collide with the RB copy.
    for (int k = 0; k < NREGS; k++) begin
`ifdef X86_STATE_STAMP_EN
      if ((k < 4) && (state_q == ST_IDLE)) begin
        live_d[k][CNT_W-1:0] = cycle_cnt_q;
      end else begin
        live_d[k] = live_d[k];
      end
`endif
      if (wr_fire_s && (wr_idx == IDX_W'(k))) begin
        live_d[k] = (live_d[k] & ~wr_mask_s) | (wr_data & wr_mask_s);
      end else begin
        live_d[k] = live_d[k];
      end
    end
  end

  // State registers; reset also aborts any copy in flight without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      cycle_cnt_q  <= {CNT_W{1'b0}};
      ckpt_valid_q <= 1'b0;
      ckpt_ack_q   <= 1'b0;
      rb_ack_q     <= 1'b0;
      rb_err_q     <= 1'b0;
      for (int k = 0; k < NREGS; k++) begin
        live_q[k]   <= {XLEN{1'b0}};
        shadow_q[k] <= {XLEN{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cycle_cnt_q  <= cycle_cnt_d;
      ckpt_valid_q <= ckpt_valid_d;
      ckpt_ack_q   <= ckpt_ack_d;
      rb_ack_q     <= rb_ack_d;
      rb_err_q     <= rb_err_d;
      for (int k = 0; k < NREGS; k++) begin
        live_q[k]   <= live_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

endmodule

// File: tb/tb_x86_state_regs.sv
// Scoreboard bench for x86_state_regs (NREGS=8, XLEN=32, CNT_W=4).
// Stimulus pushes expected values tagged with the bench cycle they are due;
// independent monitors compare them and pop acks as the DUT pulses them.
module tb_x86_state_regs;

  localparam int NREGS = 8;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              wr_ready;
  logic [2:0]        wr_idx;
  logic [1:0]        wr_size;
  logic [XLEN-1:0]   wr_data;
  logic [2:0]        rd_idx_a, rd_idx_b;
  logic [XLEN-1:0]   rd_data_a, rd_data_b;
  logic              ckpt_req, ckpt_ack, rb_req, rb_ack, rb_err;
  logic              ckpt_valid, busy;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [NREGS*XLEN-1:0] state_out;

  x86_state_regs #(.NREGS(NREGS), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_size(wr_size), .wr_data(wr_data),
    .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .ckpt_req(ckpt_req), .ckpt_ack(ckpt_ack),
    .rb_req(rb_req), .rb_ack(rb_ack), .rb_err(rb_err),
    .ckpt_valid(ckpt_valid), .busy(busy),
    .cycle_cnt(cycle_cnt), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // kind: 0 reg via state_out, 1 rd_data_a, 2 busy, 3 wr_ready,
  //       4 ckpt_valid, 5 cycle_cnt, 6 rd_data_b
  typedef struct {
    string           name;
    int              kind;
    int              idx;
    logic [XLEN-1:0] val;
    int              due;
  } chk_t;

  typedef struct {
    bit is_rb;
    bit err;
    int due;
  } ack_t;

  chk_t exq[$];
  ack_t ackq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int kind, input int idx,
                      input logic [XLEN-1:0] v, input int due);
    chk_t c;
    c.name = n; c.kind = kind; c.idx = idx; c.val = v; c.due = due;
    exq.push_back(c);
  endtask

  task automatic push_ack(input bit is_rb, input bit err, input int due);
    ack_t a;
    a.is_rb = is_rb; a.err = err; a.due = due;
    ackq.push_back(a);
  endtask

  task automatic write(input int idx, input logic [1:0] size, input logic [XLEN-1:0] data);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_size = size; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Busy / wr_ready profile of an NREGS-long copy requested at bench cycle n.
  task automatic push_window(input string n_s, input int n);
    for (int d = 1; d <= NREGS; d++) begin
      push({n_s, "_busy"}, 2, 0, 32'd1, n + d);
      push({n_s, "_wr_ready"}, 3, 0, 32'd0, n + d);
    end
    push({n_s, "_busy_end"}, 2, 0, 32'd0, n + NREGS + 1);
    push({n_s, "_wr_ready_end"}, 3, 0, 32'd1, n + NREGS + 1);
  endtask

  // Value monitor: compares every expectation that falls due this cycle.
  always @(negedge clk) begin : value_mon
    chk_t keep[$];
    logic [XLEN-1:0] act;
    keep = {};
    foreach (exq[i]) begin
      if (exq[i].due <= cyc) begin
        case (exq[i].kind)
          0: act = state_out[exq[i].idx*XLEN +: XLEN];
          1: act = rd_data_a;
          2: act = {31'd0, busy};
          3: act = {31'd0, wr_ready};
          4: act = {31'd0, ckpt_valid};
          5: act = {28'd0, cycle_cnt};
          6: act = rd_data_b;
          default: act = 32'hxxxxxxxx;
        endcase
        total++;
        if (exq[i].due != cyc || act !== exq[i].val) begin
          bad++;
          $display("FAIL %s[%0d]: got %h expected %h (cycle %0d due %0d)",
                   exq[i].name, exq[i].idx, act, exq[i].val, cyc, exq[i].due);
        end
      end else begin
        keep.push_back(exq[i]);
      end
    end
    exq = keep;
  end

  // Ack monitor: every ack pulse must match the oldest outstanding operation.
  always @(negedge clk) begin : ack_mon
    ack_t a;
    if (ckpt_ack === 1'b1 || rb_ack === 1'b1) begin
      total++;
      if (ackq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ckpt_ack=%b rb_ack=%b rb_err=%b expected none (cycle %0d)",
                 ckpt_ack, rb_ack, rb_err, cyc);
      end else begin
        a = ackq.pop_front();
        if (rb_ack !== a.is_rb || ckpt_ack !== !a.is_rb || rb_err !== a.err || cyc != a.due) begin
          bad++;
          $display("FAIL ack: got ckpt_ack=%b rb_ack=%b rb_err=%b cycle %0d expected rb=%b err=%b cycle %0d",
                   ckpt_ack, rb_ack, rb_err, cyc, a.is_rb, a.err, a.due);
        end
      end
    end else if (ackq.size() > 0 && ackq[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_ack: got none expected rb=%b by cycle %0d (now %0d)",
               ackq[0].is_rb, ackq[0].due, cyc);
      a = ackq.pop_front();
    end
  end

  initial begin : stim
    int n;
    int r0;
    rst = 1'b1; wr_en = 1'b0; wr_idx = 3'd0; wr_size = 2'd0; wr_data = 32'd0;
    rd_idx_a = 3'd0; rd_idx_b = 3'd0; ckpt_req = 1'b0; rb_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    r0 = cyc;
    push("rst_busy", 2, 0, 32'd0, r0);
    push("rst_wr_ready", 3, 0, 32'd1, r0);
    push("rst_ckpt_valid", 4, 0, 32'd0, r0);
    for (int k = 0; k < NREGS; k++) push("rst_reg", 0, k, 32'd0, r0);

`ifdef X86_STATE_STAMP_EN
    for (int d = 0; d <= 20; d++) begin
      push("stamp_cnt", 5, 0, 32'(d % 16), r0 + d);
      if (d > 0) begin
        for (int k = 0; k < 4; k++) push("stamp_reg", 0, k, 32'((d - 1) % 16), r0 + d);
      end
    end
    while (cyc <= r0 + 21) tick();
`else
    push("cnt_0", 5, 0, 32'd0, r0);
    push("cnt_1", 5, 0, 32'd1, r0 + 1);
    push("cnt_15", 5, 0, 32'd15, r0 + 15);
    push("cnt_wrap", 5, 0, 32'd0, r0 + 16);
    push("cnt_after_wrap", 5, 0, 32'd1, r0 + 17);

    // Rollback with no checkpoint: err + ack next cycle, never busy.
    n = cyc;
    rb_req = 1'b1;
    push_ack(1'b1, 1'b1, n + 1);
    push("rberr_busy", 2, 0, 32'd0, n + 1);
    push("rberr_reg", 0, 3, 32'd0, n + 1);
    tick();
    rb_req = 1'b0;
    push("rberr_busy2", 2, 0, 32'd0, cyc + 1);

    // Lane-masked writes.
    rd_idx_a = 3'd2; rd_idx_b = 3'd3;
    write(2, 2'd3, 32'h12345678);
    push("wr_full", 0, 2, 32'h12345678, cyc);
    write(2, 2'd0, 32'hFFFFFFAA);
    push("wr_byte0", 0, 2, 32'h123456AA, cyc);
    write(2, 2'd1, 32'h1111BB11);
    push("wr_byte1_rd_a", 1, 0, 32'h1234BBAA, cyc);
    write(3, 2'd3, 32'hCAFEF00D);
    write(3, 2'd2, 32'hFFFF1234);
    push("wr_half_rd_b", 6, 0, 32'hCAFE1234, cyc);

    // Checkpoint: write accepted with the request is captured; requests
    // and writes during the copy are ignored / stalled.
    for (int k = 0; k < NREGS; k++) write(k, 2'd3, 32'(8'h11 * (k + 1)));
    n = cyc;
    ckpt_req = 1'b1;
    wr_en = 1'b1; wr_idx = 3'd7; wr_size = 2'd3; wr_data = 32'h77770077;
    push_window("ckpt", n);
    push_ack(1'b0, 1'b0, n + NREGS + 1);
    push("ckpt_valid_pre", 4, 0, 32'd0, n + NREGS);
    push("ckpt_valid_set", 4, 0, 32'd1, n + NREGS + 1);
    tick();
    ckpt_req = 1'b0;
    wr_idx = 3'd1; wr_data = 32'h55555555;
    push("ckpt_same_cycle_wr", 0, 7, 32'h77770077, cyc);
    tick();
    tick();
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    while (cyc < n + NREGS + 1) tick();
    wr_en = 1'b0;
    push("stalled_wr", 0, 1, 32'h00000022, cyc);
    push("stalled_wr2", 0, 1, 32'h00000022, cyc + 1);
    tick();

    // Rollback restores the checkpointed contents one register per cycle.
    write(0, 2'd3, 32'h0000DEAD);
    push("pre_rb_reg0", 0, 0, 32'h0000DEAD, cyc);
    write(5, 2'd0, 32'h00000099);
    push("pre_rb_reg5", 0, 5, 32'h00000099, cyc);
    n = cyc;
    rb_req = 1'b1;
    push_window("rb", n);
    push_ack(1'b1, 1'b0, n + NREGS + 1);
    push("rb_reg0_early", 0, 0, 32'h00000011, n + 2);
    push("rb_reg5_early", 0, 5, 32'h00000099, n + 2);
    push("rb_reg0", 0, 0, 32'h00000011, n + NREGS + 1);
    push("rb_reg5", 0, 5, 32'h00000066, n + NREGS + 1);
    push("rb_reg7", 0, 7, 32'h77770077, n + NREGS + 1);
    push("rb_ckpt_valid", 4, 0, 32'd1, n + NREGS + 1);
    tick();
    rb_req = 1'b0;
    while (cyc < n + NREGS + 2) tick();

    // Simultaneous requests: rollback wins, no checkpoint ack.
    write(2, 2'd3, 32'h00000001);
    n = cyc;
    ckpt_req = 1'b1;
    rb_req = 1'b1;
    push_ack(1'b1, 1'b0, n + NREGS + 1);
    push("both_reg2", 0, 2, 32'h00000033, n + NREGS + 1);
    tick();
    ckpt_req = 1'b0;
    rb_req = 1'b0;
    while (cyc < n + NREGS + 2) tick();

    // Reset in the middle of a checkpoint aborts it.
    ckpt_req = 1'b1;
    tick();
    ckpt_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("abort_ckpt_valid", 4, 0, 32'd0, cyc);
    push("abort_busy", 2, 0, 32'd0, cyc);
    push("abort_wr_ready", 3, 0, 32'd1, cyc);
    push("abort_reg0", 0, 0, 32'd0, cyc);
    push("abort_reg7", 0, 7, 32'd0, cyc);
    n = cyc;
    rb_req = 1'b1;
    push_ack(1'b1, 1'b1, n + 1);
    tick();
    rb_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
`endif

    tick();
    total++;
    if (ackq.size() != 0 || exq.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d acks %0d checks pending expected 0", ackq.size(), exq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
